calc2_port_driver: RTL and testbench

- Request-side driver for one calc2 port; one instance per port (×4).
- Accepts (cmd, op1, op2) operation packets over valid/ready and allocates a free 2-bit tag.
- Drives the calc2 two-cycle request protocol, then collects the matching out_resp/out_data/out_tag.
- Returns results in completion order through a 4-entry result buffer.

---
 rtl/calc2_pkg.sv | 41 ++++
 rtl/calc2_rsp_fifo.sv | 59 +++++
 rtl/calc2_port_driver.sv | 184 ++++++++++++++++++
 tb/tb_calc2_port_driver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc2_pkg.sv
// Shared types and constants for the calc2 port driver and its result FIFO.
// Command/response encodings match the calc2 engine; tags are 2 bits (4 in flight).
package calc2_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_NONE    = 2'd0;
  localparam logic [1:0] RESP_OK      = 2'd1;
  localparam logic [1:0] RESP_ERR     = 2'd2;
  localparam logic [1:0] RESP_TIMEOUT = 2'd3;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [31:0] data1;
    logic [31:0] data2;
  } calc2_op_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } calc2_rsp_t;

  typedef enum logic [1:0] {
    DRV_IDLE = 2'd0,
    DRV_CMD  = 2'd1,
    DRV_DATA = 2'd2
  } drv_state_e;

  function automatic logic [1:0] lowest_free(input logic [3:0] busy);
    lowest_free = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!busy[i]) lowest_free = 2'(i);
    end
  endfunction

endpackage

// File: rtl/calc2_rsp_fifo.sv
// 4-entry result FIFO; head visible the cycle after push, pop takes effect next edge.
// No internal backpressure: push while full is ignored (the tag budget keeps it unreachable).
module calc2_rsp_fifo
  import calc2_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push_vld,
  input  calc2_rsp_t push_dat,
  input  logic       pop,
  output calc2_rsp_t head_dat,
  output logic       full,
  output logic       empty
);

  calc2_rsp_t mem_q [4];
  calc2_rsp_t mem_d [4];
  logic [1:0] wr_q, wr_d, rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       do_push, do_pop;

  assign full     = (cnt_q == 3'd4);
  assign empty    = (cnt_q == 3'd0);
  assign head_dat = mem_q[rd_q];
  assign do_push  = push_vld && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    for (int i = 0; i < 4; i++) mem_d[i] = mem_q[i];
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + 2'd1;
    end
    if (do_pop) rd_d = rd_q + 2'd1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/calc2_port_driver.sv
// Issues tagged ops on the two-cycle calc2 request protocol, returns results in completion order.
// Latency: CMD one cycle after accept; op_ready drops with no free tag or gap pending. Option: CALC2_DRV_TIMEOUT_EN.
module calc2_port_driver
  import calc2_pkg::*;
#(
  parameter int unsigned ISSUE_GAP   = 0,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_cmd,
  input  logic [31:0] op_data1,
  input  logic [31:0] op_data2,
  output logic [3:0]  req_cmd_in,
  output logic [31:0] req_data_in,
  output logic [1:0]  req_tag_in,
  input  logic [1:0]  out_resp,
  input  logic [31:0] out_data,
  input  logic [1:0]  out_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_resp,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_tag,
  output logic [3:0]  tags_busy,
  output logic        err_spurious
);

  drv_state_e state_q, state_d;
  calc2_op_t  op_q, op_d;
  logic [1:0] tag_q, tag_d;
  logic [2:0] gap_q, gap_d;
  logic [3:0] busy_q, busy_d;
  logic [3:0] outst_q, outst_d;
  logic       err_q, err_d;
  logic       rst_dly_q;

  logic       accept, any_free, pop, cap_hit, to_vld, push_vld;
  logic       fifo_full, fifo_empty;
  logic [1:0] free_tag, to_tag;
  calc2_rsp_t push_dat, head_dat;

  assign any_free = |(~busy_q);
  assign free_tag = lowest_free(busy_q);
  assign accept   = op_valid && op_ready;
  assign pop      = rsp_valid && rsp_ready;
  assign cap_hit  = (out_resp != RESP_NONE) && outst_q[out_tag];

  always_ff @(posedge c_clk) begin
    if (reset) state_q <= DRV_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DRV_IDLE: if (accept) state_d = DRV_CMD;
      DRV_CMD:  state_d = DRV_DATA;
      DRV_DATA: state_d = accept ? DRV_CMD : DRV_IDLE;
      default:  state_d = DRV_IDLE;
    endcase
  end

  // rst_dly_q holds op_ready low for the first cycle after reset releases.
  always_comb begin
    op_ready    = 1'b0;
    req_cmd_in  = '0;
    req_data_in = '0;
    req_tag_in  = '0;
    case (state_q)
      DRV_IDLE: op_ready = any_free && (gap_q == 3'd0) && !rst_dly_q && !reset;
      DRV_CMD: begin
        req_cmd_in  = op_q.cmd;
        req_data_in = op_q.data1;
        req_tag_in  = tag_q;
      end
      DRV_DATA: begin
        req_data_in = op_q.data2;
        op_ready    = (ISSUE_GAP == 0) && any_free && !reset;
      end
      default: op_ready = 1'b0;
    endcase
  end

  always_comb begin
    op_d    = op_q;
    tag_d   = tag_q;
    gap_d   = gap_q;
    busy_d  = busy_q;
    outst_d = outst_q;
    err_d   = err_q;
    if (accept) begin
      op_d              = '{cmd: op_cmd, data1: op_data1, data2: op_data2};
      tag_d             = free_tag;
      busy_d[free_tag]  = 1'b1;
      outst_d[free_tag] = 1'b1;
    end
    if (state_q == DRV_DATA)
      gap_d = 3'(ISSUE_GAP);
    else if (state_q == DRV_IDLE && gap_q != 3'd0)
      gap_d = gap_q - 3'd1;
    if (cap_hit) outst_d[out_tag] = 1'b0;
    if (out_resp != RESP_NONE && !outst_q[out_tag]) err_d = 1'b1;
    if (to_vld) outst_d[to_tag] = 1'b0;
    if (pop) busy_d[head_dat.tag] = 1'b0;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      op_q      <= '0;
      tag_q     <= '0;
      gap_q     <= '0;
      busy_q    <= '0;
      outst_q   <= '0;
      err_q     <= 1'b0;
      rst_dly_q <= 1'b1;
    end else begin
      op_q      <= op_d;
      tag_q     <= tag_d;
      gap_q     <= gap_d;
      busy_q    <= busy_d;
      outst_q   <= outst_d;
      err_q     <= err_d;
      rst_dly_q <= 1'b0;
    end
  end

`ifdef CALC2_DRV_TIMEOUT_EN
  logic [7:0] to_cnt_q [4];
  logic [7:0] to_cnt_d [4];

  // A timeout losing to a real capture retries next cycle (>= compare).
  always_comb begin
    to_vld = 1'b0;
    to_tag = 2'd0;
    for (int i = 0; i < 4; i++) begin
      to_cnt_d[i] = to_cnt_q[i];
      if (outst_q[i] && to_cnt_q[i] != 8'hff) to_cnt_d[i] = to_cnt_q[i] + 8'd1;
      if (accept && free_tag == 2'(i)) to_cnt_d[i] = '0;
      if (!to_vld && outst_q[i] && to_cnt_q[i] >= 8'(TIMEOUT_CYC - 1)) begin
        to_vld = 1'b1;
        to_tag = 2'(i);
      end
    end
    if (cap_hit) to_vld = 1'b0;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) to_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) to_cnt_q[i] <= to_cnt_d[i];
    end
  end
`else
  assign to_vld = 1'b0;
  assign to_tag = 2'd0;
`endif

  assign push_vld = (cap_hit || to_vld) && !fifo_full;
  assign push_dat = cap_hit ? '{resp: out_resp, data: out_data, tag: out_tag}
                            : '{resp: RESP_TIMEOUT, data: 32'd0, tag: to_tag};

  calc2_rsp_fifo u_rsp_fifo (
    .clk      (c_clk),
    .reset    (reset),
    .push_vld (push_vld),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rsp_valid    = !fifo_empty;
  assign rsp_resp     = fifo_empty ? 2'd0  : head_dat.resp;
  assign rsp_data     = fifo_empty ? 32'd0 : head_dat.data;
  assign rsp_tag      = fifo_empty ? 2'd0  : head_dat.tag;
  assign tags_busy    = busy_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_calc2_port_driver.sv
// Directed and randomized checks of calc2_port_driver against a set/queue-based model.
module tb_calc2_port_driver;
  import calc2_pkg::*;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        op_valid, op_ready;
  logic [3:0]  op_cmd;
  logic [31:0] op_data1, op_data2;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_tag;
  logic [3:0]  tags_busy;
  logic        err_spurious;

  calc2_port_driver #(.ISSUE_GAP(0), .TIMEOUT_CYC(64)) dut (
    .c_clk(c_clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_cmd(op_cmd), .op_data1(op_data1), .op_data2(op_data2),
    .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .tags_busy(tags_busy), .err_spurious(err_spurious)
  );

  always #5 c_clk = ~c_clk;

  int cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Model: set of outstanding tags, completion-ordered result queue, sticky error.
  bit         m_out [4];
  calc2_rsp_t m_q [$];
  bit         m_err;

  function automatic logic [3:0] m_busy();
    logic [3:0] b = '0;
    for (int i = 0; i < 4; i++) if (m_out[i]) b[i] = 1'b1;
    foreach (m_q[j]) b[m_q[j].tag] = 1'b1;
    return b;
  endfunction

  function automatic int m_free();
    logic [3:0] b = m_busy();
    for (int i = 0; i < 4; i++) if (!b[i]) return i;
    return -1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_out[i] = 1'b0;
    m_q.delete();
    m_err = 1'b0;
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_state(input string name);
    chk({name, "_busy"}, 64'(tags_busy), 64'(m_busy()));
    chk({name, "_err"}, 64'(err_spurious), 64'(m_err));
    chk({name, "_valid"}, 64'(rsp_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0)
      chk({name, "_head"}, 64'({rsp_resp, rsp_data, rsp_tag}), 64'(m_q[0]));
  endtask

  task automatic check_zero(input string name);
    chk({name, "_req"}, 64'({req_cmd_in, req_data_in, req_tag_in, op_ready}), 64'd0);
    chk({name, "_rsp"}, 64'({rsp_valid, rsp_resp, rsp_data, rsp_tag, tags_busy, err_spurious}), 64'd0);
  endtask

  // Leaves the DUT in the DATA cycle of the issued op; cmd_cyc = cycle count at CMD.
  task automatic send(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                      output int cmd_cyc);
    int exp_tag;
    int w = 0;
    op_valid = 1'b1; op_cmd = cmd; op_data1 = a; op_data2 = b;
    while (!op_ready && w < 16) begin tick(); w++; end
    chk("op_ready_wait", 64'(op_ready), 64'd1);
    exp_tag = m_free();
    tick();
    op_valid = 1'b0;
    if (exp_tag >= 0) m_out[exp_tag] = 1'b1;
    cmd_cyc = cyc;
    chk("cmd_req", 64'({req_cmd_in, req_data_in, req_tag_in}), 64'({cmd, a, 2'(exp_tag)}));
    tick();
    chk("data_req", 64'({req_cmd_in, req_data_in, req_tag_in}), 64'({4'd0, b, 2'd0}));
  endtask

  task automatic respond(input logic [1:0] r, input logic [31:0] d, input logic [1:0] t);
    out_resp = r; out_data = d; out_tag = t;
    tick();
    out_resp = '0; out_data = '0; out_tag = '0;
    if (m_out[t]) begin
      m_out[t] = 1'b0;
      m_q.push_back('{resp: r, data: d, tag: t});
    end else begin
      m_err = 1'b1;
    end
    check_state("respond");
  endtask

  task automatic pop_one();
    calc2_rsp_t e;
    chk("pop_valid", 64'(rsp_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      e = m_q.pop_front();
      chk("pop_head", 64'({rsp_resp, rsp_data, rsp_tag}), 64'(e));
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end else begin
      tick();
    end
    check_state("pop");
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) if (m_out[i]) respond(RESP_OK, $urandom, 2'(i));
    while (m_q.size() != 0) pop_one();
  endtask

  initial begin
    int c0, c1, c2, c3, t;
    reset = 1'b1; op_valid = 1'b0; op_cmd = '0; op_data1 = '0; op_data2 = '0;
    out_resp = '0; out_data = '0; out_tag = '0; rsp_ready = 1'b0;
    m_reset();
    tick(); tick(); tick();
    check_zero("reset_held");
    reset = 1'b0;
    #1;
    check_zero("reset_after");
    tick();
    chk("ready_after_reset", 64'(op_ready), 64'd1);

    // ADD 5 + 3 -> 8 on tag 0
    send(CMD_ADD, 32'd5, 32'd3, c0);
    tick();
    respond(RESP_OK, 32'd8, 2'd0);
    chk("add_rsp", 64'({rsp_valid, rsp_resp, rsp_data, rsp_tag}), 64'({1'b1, 2'd1, 32'd8, 2'd0}));
    tick();
    chk("add_busy_hold", 64'(tags_busy), 64'(4'b0001));
    pop_one();

    // Four back-to-back issues, fifth refused
    send(CMD_SUB, $urandom, $urandom, c0);
    send(CMD_SHL, $urandom, $urandom, c1);
    send(CMD_SHR, $urandom, $urandom, c2);
    send(4'($urandom_range(0, 15)), $urandom, $urandom, c3);
    chk("b2b_gap01", 64'(c1 - c0), 64'd2);
    chk("b2b_gap12", 64'(c2 - c1), 64'd2);
    chk("b2b_gap23", 64'(c3 - c2), 64'd2);
    op_valid = 1'b1;
    chk("fifth_not_ready_data", 64'(op_ready), 64'd0);
    tick();
    chk("fifth_not_ready_idle", 64'(op_ready), 64'd0);
    op_valid = 1'b0;
    check_state("all_busy");

    // Out-of-order completion: tag 2 then tag 0
    respond(RESP_OK, $urandom, 2'd2);
    respond(RESP_ERR, $urandom, 2'd0);
    op_valid = 1'b1;
    rsp_ready = 1'b1;
    chk("pop_tag_not_yet_free", 64'(op_ready), 64'd0);
    chk("ooo_first", 64'(rsp_tag), 64'd2);
    void'(m_q.pop_front());
    tick();
    rsp_ready = 1'b0;
    check_state("ooo_after_pop");
    send(CMD_ADD, $urandom, $urandom, c0);
    chk("ooo_realloc", 64'(m_out[2]), 64'd1);
    chk("ooo_second", 64'(rsp_tag), 64'd0);
    drain();

    // Spurious response for a tag that is not outstanding
    send(CMD_ADD, $urandom, $urandom, c0);
    respond(RESP_ERR, $urandom, 2'd3);
    chk("spurious_flag", 64'(err_spurious), 64'd1);
    drain();

    // Reset during DATA with two outstanding
    send(CMD_ADD, $urandom, $urandom, c0);
    send(CMD_SUB, $urandom, $urandom, c1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_reset();
    check_zero("reset_mid_data");
    send(CMD_ADD, $urandom, $urandom, c0);
    chk("post_reset_tag", 64'(m_out[0]), 64'd1);
    drain();

`ifdef CALC2_DRV_TIMEOUT_EN
    t = m_free();
    send(CMD_ADD, $urandom, $urandom, c0);
    begin
      int w = 0;
      while (!rsp_valid && w < 100) begin tick(); w++; end
    end
    chk("timeout_latency", 64'(cyc - c0), 64'd64);
    m_out[t] = 1'b0;
    m_q.push_back('{resp: RESP_TIMEOUT, data: 32'd0, tag: 2'(t)});
    check_state("timeout_rsp");
    respond(RESP_OK, $urandom, 2'(t));
    chk("timeout_late_spurious", 64'(err_spurious), 64'd1);
    drain();
`else
    // Randomized mix of issues, responses (including spurious), pops and idles
    for (int it = 0; it < 80; it++) begin
      int act;
      int outs [$];
      act = $urandom_range(0, 3);
      case (act)
        0: begin
          if (m_free() >= 0) send(4'($urandom_range(0, 15)), $urandom, $urandom, c0);
          else begin tick(); check_state("rand_full"); end
        end
        1: begin
          for (int i = 0; i < 4; i++) if (m_out[i]) outs.push_back(i);
          if (outs.size() != 0)
            respond(2'($urandom_range(1, 3)), $urandom, 2'(outs[$urandom_range(0, outs.size() - 1)]));
          else
            respond(2'($urandom_range(1, 3)), $urandom, 2'($urandom_range(0, 3)));
        end
        2: pop_one();
        default: begin tick(); check_state("rand_idle"); end
      endcase
    end
    drain();
    t = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
